// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin shared-adder arbiter.
package adder_arbiter_pkg;

  // Default sizing of the arbiter and its adder.
  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ID_W  = 2;

  // Arbiter FSM states; encoding matches the legacy 2-bit state values.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

endpackage : adder_arbiter_pkg

// File: rtl/adder_arbiter_core.sv
// Combinational unsigned adder producing a WIDTH-bit sum and carry-out.
module adder_core
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_full;

  // Full WIDTH+1-bit sum so the top bit is the carry-out.
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b};
  end

  assign sum  = w_full[WIDTH-1:0];
  assign cout = w_full[WIDTH];

endmodule : adder_core

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between N_REQ requesters.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ID_W  = DEF_ID_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic                   busy,
  output logic [7:0]             done_count
);

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_last_grant;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [ID_W-1:0]   r_op_id;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [WIDTH-1:0]  r_rsp_sum;
  logic              r_rsp_carry;
  logic [7:0]        r_done_count;

  logic              w_found;
  logic [ID_W-1:0]   w_win_id;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;

  // Round-robin search: first valid requester starting just after the last grant.
  // The outer loop walks priority order; the inner loop turns the rotated
  // position back into a constant index so no variable bit-select is needed.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!w_found && req_valid[i] &&
            (i == ((32'(r_last_grant) + k) % N_REQ))) begin
          w_found  = 1'b1;
          w_win_id = ID_W'(i);
        end
      end
    end
  end

  // Operand mux selecting the winner's packed operand slices.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_win_id == ID_W'(i)) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot grant, only offered while idle.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_found) begin
      req_ready = N_REQ'(1) << w_win_id;
    end
  end

  adder_core #(
    .WIDTH (WIDTH)
  ) u_adder_core (
    .a    (r_op_a),
    .b    (r_op_b),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Arbiter FSM: accept a request, run the add, hold the response until taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_id      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_sum    <= '0;
      r_rsp_carry  <= 1'b0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_op_id      <= w_win_id;
            r_last_grant <= w_win_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_sum   <= w_sum;
          r_rsp_carry <= w_cout;
          r_rsp_id    <= r_op_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + 8'd1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_carry  = r_rsp_carry;
  assign busy       = (r_state != S_IDLE);
  assign done_count = r_done_count;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (N_REQ=4, WIDTH=8, ID_W=2).
module tb_adder_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic        busy;
  logic [7:0]  done_count;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] sum;
    logic       carry;
  } exp_t;

  exp_t sb_q[$];
  exp_t got;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_done;
  logic [7:0] wa, wb;
  logic [8:0] ws;
  int   order[5] = '{0, 1, 2, 3, 0};
  int   waited;

  adder_arbiter #(
    .N_REQ (4),
    .WIDTH (8),
    .ID_W  (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .done_count (done_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sole requester `id` issues one add; rsp_ready must be 1.
  task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ec);
    logic [3:0] sel;
    sel = 4'b0001 << id;
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid = sel;
    #1;
    chk("grant_sole", 32'(req_ready), 32'(sel));
    sb_q.push_back('{id: 2'(id), sum: es, carry: ec});
    tick();
    req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid_low", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready_zero", 32'(req_ready), 32'd0);
    tick();
    chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    tick();
    exp_done = exp_done + 8'd1;
    chk("done_count", 32'(done_count), 32'(exp_done));
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: one-hot grant every cycle, and response checking on handshake.
  always @(negedge clock) begin
    if (!reset) begin
      chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          got = sb_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(got.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(got.sum));
          chk("rsp_carry", 32'(rsp_carry), 32'(got.carry));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    exp_done  = '0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);
    reset = 1'b0;
    tick();

    // Basic and boundary arithmetic.
    single_op(0, 8'd3, 8'd2, 8'd5, 1'b0);
    single_op(2, 8'd255, 8'd1, 8'd0, 1'b1);
    single_op(2, 8'd200, 8'd100, 8'd44, 1'b1);

    // Reset while in EXEC: operation discarded, no response.
    req_a[15:8] = 8'd40;
    req_b[15:8] = 8'd2;
    req_valid   = 4'b0010;
    #1;
    chk("grant_before_rst", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    chk("in_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done_count), 32'd0);
    tick();
    tick();
    reset    = 1'b0;
    exp_done = '0;
    tick();
    tick();
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // All four requesting: rotation 0,1,2,3,0, one grant every 3 cycles.
    req_a = {8'd31, 8'd21, 8'd11, 8'd1};
    req_b = {8'd8, 8'd7, 8'd6, 8'd5};
    sb_q.push_back('{id: 2'd0, sum: 8'd6,  carry: 1'b0});
    sb_q.push_back('{id: 2'd1, sum: 8'd17, carry: 1'b0});
    sb_q.push_back('{id: 2'd2, sum: 8'd28, carry: 1'b0});
    sb_q.push_back('{id: 2'd3, sum: 8'd39, carry: 1'b0});
    sb_q.push_back('{id: 2'd0, sum: 8'd6,  carry: 1'b0});
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (req_ready == '0 && waited < 10) begin
        tick();
        waited++;
      end
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << order[g]));
      if (g > 0) chk("rr_interval", 32'(waited + 1), 32'd3);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    exp_done = exp_done + 8'd5;
    chk("rr_done", 32'(done_count), 32'(exp_done));

    // Back-pressure with requester 1 waiting.
    rsp_ready   = 1'b0;
    req_a[31:24] = 8'd7;
    req_b[31:24] = 8'd9;
    req_valid   = 4'b1000;
    #1;
    chk("bp_grant3", 32'(req_ready), 32'b1000);
    sb_q.push_back('{id: 2'd3, sum: 8'd16, carry: 1'b0});
    tick();
    req_a[15:8] = 8'd50;
    req_b[15:8] = 8'd60;
    req_valid   = 4'b0010;
    sb_q.push_back('{id: 2'd1, sum: 8'd110, carry: 1'b0});
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_sum", 32'(rsp_sum), 32'd16);
      chk("bp_rsp_id", 32'(rsp_id), 32'd3);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_still_zero", 32'(req_ready), 32'd0);
    tick();
    chk("bp_grant1_after", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    exp_done = exp_done + 8'd2;
    chk("bp_done", 32'(done_count), 32'(exp_done));

    // 256 operations from a clean reset: done_count wraps to 0.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_done = '0;
    tick();
    for (int i = 0; i < 256; i++) begin
      wa = 8'(i);
      wb = 8'(i * 37 + 11);
      ws = {1'b0, wa} + {1'b0, wb};
      single_op(i % 4, wa, wb, ws[7:0], ws[8]);
      if (i == 254) chk("done_255", 32'(done_count), 32'd255);
    end
    chk("done_wrap", 32'(done_count), 32'd0);

    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adder_arbiter
